// File: rtl/id_counter_pkg.sv
// rtl/id_counter_pkg.sv - request encoding and resolution helper for the DPLL id_counter
package id_counter_pkg;

    // Net phase-correction request seen on a clock edge after merging pulses and pendings.
    typedef enum logic [1:0] {
        REQ_NONE    = 2'd0,
        REQ_ADVANCE = 2'd1,
        REQ_RETARD  = 2'd2
    } req_e;

    // An advance and a retard seen together cancel out entirely.
    function automatic req_e resolve_req(input logic ei, input logic ed);
        req_e r;
        r = REQ_NONE;
        if (ei && !ed) begin
            r = REQ_ADVANCE;
        end else if (ed && !ei) begin
            r = REQ_RETARD;
        end
        return r;
    endfunction

endpackage

// File: rtl/id_counter.sv
// rtl/id_counter.sv - increment/decrement counter (DCO) producing the DPLL IDout square wave
module id_counter
    import id_counter_pkg::*;
#(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic IDout
);

    localparam int CNT_W = $clog2(HALF_PERIOD + 1);

    // Terminal counts: an advance ends the half-period one edge early, a retard one edge late.
    localparam logic [CNT_W-1:0] TERM_ADV = CNT_W'(HALF_PERIOD - 2);
    localparam logic [CNT_W-1:0] TERM_NOM = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] TERM_RET = CNT_W'(HALF_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             idout_q, idout_d;
    logic             inc_pend_q, inc_pend_d;
    logic             dec_pend_q, dec_pend_d;

    logic             ei;
    logic             ed;
    req_e             req;
    logic [CNT_W-1:0] term;

    // Merge live pulses with pendings, pick the terminal count, and advance or wrap the counter.
    always_comb begin
        ei   = inc | inc_pend_q;
        ed   = dec | dec_pend_q;
        req  = resolve_req(ei, ed);
        term = TERM_NOM;
        case (req)
            REQ_ADVANCE: term = TERM_ADV;
            REQ_RETARD:  term = TERM_RET;
            default:     term = TERM_NOM;
        endcase

        cnt_d      = cnt_q;
        idout_d    = idout_q;
        inc_pend_d = 1'b0;
        dec_pend_d = 1'b0;

        // >= rather than == so a late advance (counter already past the short terminal) toggles now.
        if (cnt_q >= term) begin
            idout_d = ~idout_q;
            cnt_d   = '0;
        end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            inc_pend_d = (req == REQ_ADVANCE);
            dec_pend_d = (req == REQ_RETARD);
        end
    end

    // State registers; reset aborts the half-period and drops any pending correction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            idout_q    <= 1'b0;
            inc_pend_q <= 1'b0;
            dec_pend_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idout_q    <= idout_d;
            inc_pend_q <= inc_pend_d;
            dec_pend_q <= dec_pend_d;
        end
    end

    assign IDout = idout_q;

endmodule

// File: tb/tb_id_counter.sv
// tb/tb_id_counter.sv - self-checking bench for id_counter with a half-period-length reference model
`timescale 1ns/100ps
module tb_id_counter;

    localparam int HP = 4;

    logic clk;
    logic reset;
    logic inc;
    logic dec;
    logic IDout;

    int total;
    int bad;

    // reference model: edges elapsed in current half, pending length adjustment, output level
    int   m_edges;
    int   m_adj;
    logic m_out;

    // observed half-period measurement
    int   since;
    int   last_len;
    logic toggled;
    logic prev_out;

    id_counter #(.HALF_PERIOD(HP)) dut (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .dec   (dec),
        .IDout (IDout)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_edges  = 0;
        m_adj    = 0;
        m_out    = 1'b0;
        since    = 0;
        prev_out = 1'b0;
    endtask

    // The half-period in progress lasts HP edges, shortened/lengthened by one if a correction is active.
    task automatic model_step(input logic i, input logic d);
        bit want_adv;
        bit want_ret;
        int adj;
        want_adv = i || (m_adj < 0);
        want_ret = d || (m_adj > 0);
        adj = 0;
        if (want_adv && !want_ret) adj = -1;
        if (want_ret && !want_adv) adj = 1;
        m_edges++;
        if (m_edges >= HP + adj) begin
            m_out   = ~m_out;
            m_edges = 0;
            m_adj   = 0;
        end else begin
            m_adj = adj;
        end
    endtask

    task automatic tick(input logic i, input logic d);
        inc = i;
        dec = d;
        @(posedge clk);
        model_step(i, d);
        #0.5;
        inc = 1'b0;
        dec = 1'b0;
        since++;
        toggled = (IDout !== prev_out);
        if (toggled) begin
            last_len = since;
            since    = 0;
        end
        prev_out = IDout;
        check_eq("idout_vs_model", int'(IDout), int'(m_out));
    endtask

    task automatic wait_toggle(input string tag, input int exp_len);
        int n;
        n = 0;
        toggled = 1'b0;
        while (!toggled && n < 3 * HP) begin
            tick(1'b0, 1'b0);
            n++;
        end
        if (!toggled) begin
            check_eq({tag, "_timeout"}, n, -1);
        end else begin
            check_eq(tag, last_len, exp_len);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        inc   = 1'b0;
        dec   = 1'b0;
        reset = 1'b0;
        toggled  = 1'b0;
        last_len = 0;
        model_reset();

        #50;
        check_eq("reset_idout", int'(IDout), 0);
        #50;
        reset = 1'b1;

        wait_toggle("nominal_first", 4);
        wait_toggle("nominal_second", 4);

        // single inc at cnt=1
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        wait_toggle("inc_short", 3);
        wait_toggle("inc_after", 4);

        // single dec at cnt=1
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        wait_toggle("dec_long", 5);
        wait_toggle("dec_after", 4);

        // inc and dec together
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        wait_toggle("both_same", 4);

        // inc then dec in one half-period
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        wait_toggle("inc_then_dec", 4);

        // two incs merge into one advance
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        wait_toggle("two_inc", 3);
        wait_toggle("two_inc_after", 4);

        // late inc: counter already at nominal-1 toggles on the arrival edge
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_eq("late_inc_toggle", int'(toggled), 1);
        check_eq("late_inc_len", last_len, 3);
        wait_toggle("late_inc_after", 4);

        // reset mid half-period with inc pending while IDout is high
        if (m_out == 1'b0) wait_toggle("align_high", 4);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_eq("pre_reset_high", int'(IDout), 1);
        reset = 1'b0;
        #0.2;
        check_eq("async_reset_idout", int'(IDout), 0);
        repeat (3) @(posedge clk);
        #0.5;
        reset = 1'b1;
        model_reset();
        wait_toggle("post_reset_first", 4);
        wait_toggle("post_reset_second", 4);

        // randomized sparse inc/dec pulses against the model
        for (int k = 0; k < 600; k++) begin
            int r;
            r = $urandom_range(0, 15);
            tick(r == 0 || r == 2, r == 1 || r == 2);
        end

        // randomized resets interleaved with traffic
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(3, 20)) tick($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            reset = 1'b0;
            #0.2;
            check_eq("rand_reset_idout", int'(IDout), 0);
            @(posedge clk);
            #0.5;
            reset = 1'b1;
            model_reset();
        end
        for (int k = 0; k < 100; k++) tick($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
